// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan controller.
package fnd_pkg;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV_DEF = 100_000;
  localparam int GUARD_DEF    = 1_000;

  localparam logic [3:0] CODE_DOT   = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef logic [DIGITS-1:0] com_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GUARD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/fnd_scan_ctrl_bcd_to_seg.sv
// Digit code to active-low {g..a} segment pattern; E and F light nothing so dp can stand alone.
module bcd_to_seg (
  input  logic [3:0] code,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = 7'h7F;
    case (code)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      default: seg7 = 7'h7F;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed FND scanner with per-digit guard gap and per-frame value snapshot.
// Optional leading-zero blanking when FND_LZ_BLANK_EN is defined.
//
//   state    | meaning
//   ST_INIT  | first edge after reset: take snapshot, outputs held at reset values
//   ST_SHOW  | cnt < SCAN_DIV-GUARD: selected common driven (if en)
//   ST_GUARD | trailing GUARD cycles of the window: all commons off
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int GUARD    = GUARD_DEF
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dot_en,
  output logic [7:0]  seg,
  output logic [3:0]  com,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SHOW_LEN = CW'(SCAN_DIV - GUARD);

  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic [3:0]    digit;
  logic [3:0]    code;
  logic [6:0]    seg7;

`ifdef FND_LZ_BLANK_EN
  logic [3:0] lz;
`endif

  always_comb begin
    cnt_inc = cnt + CW'(1);
    digit   = snap[{idx, 2'b00} +: 4];
`ifdef FND_LZ_BLANK_EN
    // A digit is blank only if it and every digit to its left are zero.
    lz    = 4'b0000;
    lz[3] = (snap[15:12] == 4'h0);
    lz[2] = lz[3] && (snap[11:8] == 4'h0);
    lz[1] = lz[2] && (snap[7:4] == 4'h0);
    code  = lz[idx] ? (dot_en[idx] ? CODE_DOT : CODE_BLANK) : digit;
`else
    code  = digit;
`endif
  end

  bcd_to_seg u_dec (
    .code (code),
    .seg7 (seg7)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= ST_INIT;
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      com        <= 4'hF;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          snap       <= value;
          com        <= 4'hF;
          seg        <= 8'hFF;
          frame_done <= 1'b0;
          state      <= ST_SHOW;
        end
        default: begin
          seg        <= {~dot_en[idx], seg7};
          com        <= (state == ST_SHOW && en) ? ~(com_t'(1) << idx) : 4'hF;
          frame_done <= (cnt == '0) && (idx == 2'd0);
          if (cnt == LAST) begin
            cnt   <= '0;
            idx   <= idx + 2'd1;
            state <= ST_SHOW;
            // Latch the next frame's value as digit 3 finishes.
            if (idx == 2'd3)
              snap <= value;
          end else begin
            cnt   <= cnt_inc;
            state <= (cnt_inc < SHOW_LEN) ? ST_SHOW : ST_GUARD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: cycle-count model plus directed literal checks.
module tb_fnd_scan_ctrl;

  localparam int SD    = 8;
  localparam int G     = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dot_en;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  fnd_scan_ctrl #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .en         (en),
    .value      (value),
    .dot_en     (dot_en),
    .seg        (seg),
    .com        (com),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Model: outputs depend only on edges elapsed since reset release.
  int          k;
  logic [15:0] m_snap;
  logic [3:0]  exp_com;
  logic [7:0]  exp_seg;
  logic        exp_fd;

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      k       <= 0;
      m_snap  <= '0;
      exp_com <= 4'hF;
      exp_seg <= 8'hFF;
      exp_fd  <= 1'b0;
    end else begin : step_model
      automatic int kn = k + 1;
      automatic int t, w, d, c;
      automatic logic [3:0] dig;
      automatic logic blank;
      k <= kn;
      if (kn >= 2) begin
        t     = kn - 2;
        w     = t % FRAME;
        d     = w / SD;
        c     = w % SD;
        dig   = 4'((m_snap >> (4 * d)) & 16'h000F);
        blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
        blank = (d > 0) && ((m_snap >> (4 * d)) == 16'h0);
`endif
        exp_seg <= {~dot_en[d], blank ? 7'h7F : glyph(dig)};
        exp_com <= (c < SD - G && en) ? ~(4'b0001 << d) : 4'hF;
        exp_fd  <= (w == 0);
      end
      if ((kn - 1) % FRAME == 0)
        m_snap <= value;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (com !== exp_com || seg !== exp_seg || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL model k=%0d got com=%h seg=%h fd=%b required com=%h seg=%h fd=%b",
                 k, com, seg, frame_done, exp_com, exp_seg, exp_fd);
      end
    end
  end

  task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic look(input string nm, input logic [3:0] c, input logic [7:0] s, input logic fd);
    lit({nm, "_com"}, {4'h0, com}, {4'h0, c});
    lit({nm, "_seg"}, seg, s);
    lit({nm, "_fd"}, {7'h0, frame_done}, {7'h0, fd});
  endtask

  initial begin
    reset_p = 1'b1;
    value   = 16'h1234;
    en      = 1'b1;
    dot_en  = 4'b0000;
    step(3);
    armed = 1'b1;
    look("rst_hold", 4'hF, 8'hFF, 1'b0);
    reset_p = 1'b0;

    step(1); look("rel_c1", 4'hF, 8'hFF, 1'b0);
    step(1); look("d0_t0", 4'hE, 8'h99, 1'b1);
    step(8); look("d1_t8", 4'hD, 8'hB0, 1'b0);
    step(8); look("d2_t16", 4'hB, 8'hA4, 1'b0);
    step(8); look("d3_t24", 4'h7, 8'hF9, 1'b0);
    step(6); look("guard_t30", 4'hF, 8'hF9, 1'b0);
    step(2); look("wrap_t32", 4'hE, 8'h99, 1'b1);

    step(8);
    value = 16'h5678;
    look("snap_d1", 4'hD, 8'hB0, 1'b0);
    step(8); look("snap_d2", 4'hB, 8'hA4, 1'b0);
    step(8); look("snap_d3", 4'h7, 8'hF9, 1'b0);
    step(8); look("snap_new", 4'hE, 8'h80, 1'b1);

    value  = 16'h0000;
    dot_en = 4'b0010;
    step(32); look("dot_d0", 4'hE, 8'hC0, 1'b1);
`ifdef FND_LZ_BLANK_EN
    step(8); look("dot_d1", 4'hD, 8'h7F, 1'b0);
`else
    step(8); look("dot_d1", 4'hD, 8'h40, 1'b0);
`endif
    en = 1'b0;
    step(1); lit("en0_com", {4'h0, com}, 8'h0F);
`ifdef FND_LZ_BLANK_EN
    step(7); look("en0_d2", 4'hF, 8'hFF, 1'b0);
`else
    step(7); look("en0_d2", 4'hF, 8'hC0, 1'b0);
`endif

    en     = 1'b1;
    dot_en = 4'b0000;
    value  = 16'h0007;
    step(16); look("lz_d0", 4'hE, 8'hF8, 1'b1);
`ifdef FND_LZ_BLANK_EN
    step(8); look("lz_d1", 4'hD, 8'hFF, 1'b0);
    dot_en = 4'b0100;
    step(8); look("lz_d2dot", 4'hB, 8'h7F, 1'b0);
`else
    step(8); look("lz_d1", 4'hD, 8'hC0, 1'b0);
    dot_en = 4'b0100;
    step(8); look("lz_d2dot", 4'hB, 8'h40, 1'b0);
`endif

    step(2);
    @(posedge clk);
    #2 reset_p = 1'b1;
    #1 look("async_rst", 4'hF, 8'hFF, 1'b0);
    value = 16'h4321;
    step(2);
    reset_p = 1'b0;
    step(1); look("rst2_c1", 4'hF, 8'hFF, 1'b0);
    step(1); look("rst2_d0", 4'hE, 8'hF9, 1'b1);
    step(32); look("rst2_f1", 4'hE, 8'hF9, 1'b1);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
